tlb_unit: RTL and testbench
===========================

Name: tlb_unit

Overview:
- 16-entry joint TLB directly downstream of the CP0 register file.
- Consumes CP0's TLBWI/TLBR/TLBP controls (index, write data, EntryHi, ASID, kseg0 cacheability) and returns read data and probe index.
- Translates instruction-fetch and data-access virtual addresses with registered responses.
- Reports TLB exceptions (exccode, refill flag, badvaddr) back toward CP0.

Parameters:
- TLB_ENTRIES, 16, number of entries; index width IDX_W = $clog2(TLB_ENTRIES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tlbrw_we  in  1  TLBWI strobe; write tlbrw_wdata to entry tlbrw_index
- tlbrw_index  in  IDX_W  entry for TLBWI/TLBR
- tlbrw_wdata  in  78  tlb_entry_t {c0,c1,asid,vpn2,pfn0,pfn1,d0,v0,d1,v1,G}
- tlbrw_rdata  out  78  entry[tlbrw_index], combinational
- tlbp_entry_hi  in  32  EntryHi for probe
- tlbp_index  out  32  probe result, combinational
- tlb_asid  in  8  current ASID for translation
- kseg0_uncached  in  1  Config0.K0 != 3
- i_req / i_ready / i_vaddr  in / out / in  1 / 1 / 32  fetch lookup request
- i_resp_valid, i_paddr, i_cached, i_ex, i_exccode, i_refill  out  1, 32, 1, 1, 5, 1  fetch response
- d_req / d_vaddr / d_is_store  in  1 / 32 / 1  data lookup request
- d_resp_valid, d_paddr, d_cached, d_ex, d_exccode, d_refill  out  1, 32, 1, 1, 5, 1  data response

Behaviour:
- Reset:
  - all entries' v0, v1 and G cleared.
  - all *_resp_valid, *_ex, *_refill = 0; paddr = 0.
  - i_ready = 1.
  - A reset mid-operation discards any in-flight lookup.
- Write: at posedge with tlbrw_we, entry[tlbrw_index] <= tlbrw_wdata.
- Read: tlbrw_rdata reflects the entry as stored before any same-cycle write.
- Match rule: entry.vpn2 == va[31:13] && (entry.G || entry.asid == asid).
  - Multiple matches: lowest index wins.
- Probe: on hit, tlbp_index = {1'b0, zero-extended index}; on miss, tlbp_index = 32'h8000_0000. Probe uses tlbp_entry_hi[7:0] as ASID.
- Lookup latency: request accepted at cycle N; response registered and valid at N+1 for exactly one cycle. A new request is accepted every cycle.
- Lookups sample entries before any same-cycle write. A write at N is visible to requests at N+1.
- Segments:
  - va[31:30] == 2'b10 (kseg0/kseg1) is unmapped: paddr = {3'b0, va[28:0]}.
  - Cached = (kseg0 && !kseg0_uncached); kseg1 is never cached.
  - All other segments are mapped.
- Mapped translation:
  - va[12] selects odd (pfn1/v1/d1/c1) vs even half; paddr = {pfn, va[11:0]}.
  - Cached = (c == 3).
- Exceptions (registered alongside the response; exccode is 0 when ex = 0):
  - no match: ex = 1, refill = 1, exccode = TLBL (fetch/load) or TLBS (store).
  - match but v = 0: ex = 1, refill = 0, same exccode.
  - store with d = 0: ex = 1, exccode = MOD, refill = 0.
- Fetch port: i_ready is always 1 unless the optional feature is enabled. d_is_store is ignored for fetch; fetch is always a load.

Optional Feature:
- Macro ITLB_MICRO_EN.
- Defined: the fetch port has a one-entry micro-TLB holding {vpn2, odd, asid, pfn, c, v, valid}.
  - Micro hit: response at N+1, as above.
  - Micro miss: FSM IDLE -> FILL. The micro entry is filled from the main array at N+1, i_ready = 0 at N+1, and the response comes at N+2. The FSM then returns to IDLE.
  - Micro entry is invalidated on tlbrw_we, on any tlb_asid change, and on reset.
  - Main-array misses and invalid entries are never cached; they produce the exception response at N+2.
  - Unmapped addresses bypass the micro-TLB at N+1.
- Undefined: fetch latency is always 1 cycle and i_ready is tied to 1.

Decomposition:
- Shared package holds: tlb_entry_t, the TLB_ENTRIES_NUM constant, the EXCCODE_TLBL/TLBS/MOD codes and the TLBOP_* indices (shared with CP0).
- One sub-module, tlb_lookup: combinational match plus even/odd selection. Instantiated three times (fetch, data, probe).

Test Plan:
- TLBWI index 3: vpn2 = 0x00010, asid = 0x05, pfn0 = 0x12345, v0 = 1, d0 = 1, c0 = 3. Then d_req va = 0x0002_0ABC, load, asid = 5 -> next cycle paddr = 0x1234_5ABC, cached = 1, ex = 0.
- Same entry, asid = 6, G = 0 -> ex = 1, exccode = TLBL, refill = 1. TLBP with EntryHi = 0x0002_0005 -> tlbp_index = 3. With EntryHi = 0x0002_0006 -> 0x8000_0000.
- Store to va = 0x0002_0ABC with d0 = 0 -> exccode = MOD. Access to va = 0x0002_1000 with v1 = 0 -> exccode = TLBS, refill = 0.
- i_req va = 0xBFC0_0000 -> paddr = 0x1FC0_0000, cached = 0. va = 0x8000_1000 with kseg0_uncached = 0 -> paddr = 0x0000_1000, cached = 1.
- TLBWI at cycle N and a lookup of the same page at N (old mapping) and N+1 (new mapping) -> responses reflect the old then the new mapping. Reset asserted while a request is in flight -> no resp_valid the next cycle.
- ITLB_MICRO_EN: two fetches to the same page -> first has 2-cycle latency with i_ready low one cycle, second has 1-cycle latency. After TLBWI, the next fetch takes 2 cycles again.

Source files
------------

// File: rtl/tlb_unit_pkg.sv
// Shared TLB types, exception codes and CP0 TLB-op indices for tlb_unit and CP0.
// Also holds the translation helper used by every lookup port.
package tlb_unit_pkg;

    localparam int TLB_ENTRIES_NUM = 16;

    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;

    localparam int TLBOP_TLBR  = 0;
    localparam int TLBOP_TLBWI = 1;
    localparam int TLBOP_TLBP  = 2;

    typedef struct packed {
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic [7:0]  asid;
        logic [18:0] vpn2;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic        d0;
        logic        v0;
        logic        d1;
        logic        v1;
        logic        g;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic        ex;
        logic [4:0]  exccode;
        logic        refill;
    } tlb_resp_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        v;
    } micro_entry_t;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_FILL
    } fetch_state_e;

    // Segment decode plus exception priority: miss, then invalid, then store to clean page.
    function automatic tlb_resp_t tlb_translate(
        input logic [31:0] va,
        input logic        is_store,
        input logic        kseg0_uncached,
        input logic        hit,
        input logic [19:0] pfn,
        input logic [2:0]  c,
        input logic        d,
        input logic        v
    );
        tlb_resp_t r;
        r = '0;
        if (va[31:30] == 2'b10) begin
            r.paddr  = {3'b000, va[28:0]};
            r.cached = !va[29] && !kseg0_uncached;
        end else begin
            r.paddr  = {pfn, va[11:0]};
            r.cached = (c == 3'd3);
            if (!hit) begin
                r.ex      = 1'b1;
                r.refill  = 1'b1;
                r.exccode = is_store ? EXCCODE_TLBS : EXCCODE_TLBL;
            end else if (!v) begin
                r.ex      = 1'b1;
                r.exccode = is_store ? EXCCODE_TLBS : EXCCODE_TLBL;
            end else if (is_store && !d) begin
                r.ex      = 1'b1;
                r.exccode = EXCCODE_MOD;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_unit_lookup.sv
// Combinational fully-associative match over the TLB array with even/odd half select.
// Lowest matching index wins when several entries hit.
module tlb_lookup
    import tlb_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_NUM,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  tlb_entry_t        entries [TLB_ENTRIES],
    input  logic [18:0]       vpn2,
    input  logic              odd,
    input  logic [7:0]        asid,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [19:0]       pfn,
    output logic [2:0]        c,
    output logic              d,
    output logic              v
);

    tlb_entry_t sel;

    // Scan downward so the last (lowest) match overrides higher ones.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        sel = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                sel = entries[i];
            end
        end
    end

    always_comb begin
        pfn = odd ? sel.pfn1 : sel.pfn0;
        c   = odd ? sel.c1   : sel.c0;
        d   = odd ? sel.d1   : sel.d0;
        v   = odd ? sel.v1   : sel.v0;
    end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: TLBWI/TLBR/TLBP for CP0 plus registered fetch and data translation ports.
// Optional ITLB_MICRO_EN adds a one-entry fetch micro-TLB with a two-cycle fill on miss.
module tlb_unit
    import tlb_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_NUM,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tlbrw_we,
    input  logic [IDX_W-1:0] tlbrw_index,
    input  tlb_entry_t       tlbrw_wdata,
    output tlb_entry_t       tlbrw_rdata,
    input  logic [31:0]      tlbp_entry_hi,
    output logic [31:0]      tlbp_index,
    input  logic [7:0]       tlb_asid,
    input  logic             kseg0_uncached,
    input  logic             i_req,
    output logic             i_ready,
    input  logic [31:0]      i_vaddr,
    output logic             i_resp_valid,
    output logic [31:0]      i_paddr,
    output logic             i_cached,
    output logic             i_ex,
    output logic [4:0]       i_exccode,
    output logic             i_refill,
    input  logic             d_req,
    input  logic [31:0]      d_vaddr,
    input  logic             d_is_store,
    output logic             d_resp_valid,
    output logic [31:0]      d_paddr,
    output logic             d_cached,
    output logic             d_ex,
    output logic [4:0]       d_exccode,
    output logic             d_refill
);

    tlb_entry_t entries [TLB_ENTRIES];

    // Only valid/global bits are reset; the rest of each entry is don't-care until written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entries[i].v0 <= 1'b0;
                entries[i].v1 <= 1'b0;
                entries[i].g  <= 1'b0;
            end
        end else if (tlbrw_we) begin
            entries[tlbrw_index] <= tlbrw_wdata;
        end
    end

    assign tlbrw_rdata = entries[tlbrw_index];

    logic             p_hit;
    logic [IDX_W-1:0] p_idx;
    logic [19:0]      p_unused_pfn;
    logic [2:0]       p_unused_c;
    logic             p_unused_d;
    logic             p_unused_v;
    logic [4:0]       p_unused_hi;

    assign p_unused_hi = tlbp_entry_hi[12:8];

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe (
        .entries (entries),
        .vpn2    (tlbp_entry_hi[31:13]),
        .odd     (1'b0),
        .asid    (tlbp_entry_hi[7:0]),
        .hit     (p_hit),
        .idx     (p_idx),
        .pfn     (p_unused_pfn),
        .c       (p_unused_c),
        .d       (p_unused_d),
        .v       (p_unused_v)
    );

    assign tlbp_index = p_hit ? {1'b0, 31'(p_idx)} : 32'h8000_0000;

    // ---- data port: lookup at p0, registered response at p1
    logic             d_hit;
    logic [IDX_W-1:0] d_unused_idx;
    logic [19:0]      d_pfn;
    logic [2:0]       d_c;
    logic             d_d;
    logic             d_v;
    tlb_resp_t        d_resp_p0;
    tlb_resp_t        d_resp_p1;
    logic             d_vld_p1;

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_dlook (
        .entries (entries),
        .vpn2    (d_vaddr[31:13]),
        .odd     (d_vaddr[12]),
        .asid    (tlb_asid),
        .hit     (d_hit),
        .idx     (d_unused_idx),
        .pfn     (d_pfn),
        .c       (d_c),
        .d       (d_d),
        .v       (d_v)
    );

    assign d_resp_p0 = tlb_translate(d_vaddr, d_is_store, kseg0_uncached,
                                     d_hit, d_pfn, d_c, d_d, d_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            d_vld_p1  <= 1'b0;
            d_resp_p1 <= '0;
        end else begin
            d_vld_p1  <= d_req;
            d_resp_p1 <= d_req ? d_resp_p0 : '0;
        end
    end

    assign d_resp_valid = d_vld_p1;
    assign d_paddr      = d_resp_p1.paddr;
    assign d_cached     = d_resp_p1.cached;
    assign d_ex         = d_resp_p1.ex;
    assign d_exccode    = d_resp_p1.exccode;
    assign d_refill     = d_resp_p1.refill;

    // ---- fetch port
    logic             i_hit;
    logic [IDX_W-1:0] i_unused_idx;
    logic [19:0]      i_pfn;
    logic [2:0]       i_c;
    logic             i_d;
    logic             i_v;
    logic [31:0]      i_look_va;
    tlb_resp_t        i_resp_p1;
    logic             i_vld_p1;

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_ilook (
        .entries (entries),
        .vpn2    (i_look_va[31:13]),
        .odd     (i_look_va[12]),
        .asid    (tlb_asid),
        .hit     (i_hit),
        .idx     (i_unused_idx),
        .pfn     (i_pfn),
        .c       (i_c),
        .d       (i_d),
        .v       (i_v)
    );

`ifdef ITLB_MICRO_EN
    fetch_state_e state, state_nx;
    logic [31:0]  fill_va_p1;
    logic         mt_valid;
    micro_entry_t mt;
    logic [7:0]   asid_q;
    logic         mt_hit;
    logic         resp_load;
    logic         fill_en;
    tlb_resp_t    resp_nx;

    assign i_look_va = fill_va_p1;
    assign mt_hit    = mt_valid && mt.vpn2 == i_vaddr[31:13] && mt.odd == i_vaddr[12]
                       && mt.asid == tlb_asid;

    always_comb begin
        state_nx  = state;
        i_ready   = 1'b1;
        resp_load = 1'b0;
        fill_en   = 1'b0;
        resp_nx   = '0;
        case (state)
            FETCH_IDLE: begin
                if (i_req) begin
                    if (i_vaddr[31:30] == 2'b10) begin
                        resp_load = 1'b1;
                        resp_nx   = tlb_translate(i_vaddr, 1'b0, kseg0_uncached,
                                                  1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
                    end else if (mt_hit) begin
                        resp_load = 1'b1;
                        resp_nx   = tlb_translate(i_vaddr, 1'b0, kseg0_uncached,
                                                  1'b1, mt.pfn, mt.c, 1'b1, mt.v);
                    end else begin
                        state_nx = FETCH_FILL;
                    end
                end
            end
            FETCH_FILL: begin
                i_ready   = 1'b0;
                resp_load = 1'b1;
                resp_nx   = tlb_translate(fill_va_p1, 1'b0, kseg0_uncached,
                                          i_hit, i_pfn, i_c, i_d, i_v);
                fill_en   = i_hit && i_v;
                state_nx  = FETCH_IDLE;
            end
            default: state_nx = FETCH_IDLE;
        endcase
    end

    // A TLB write or ASID change in the fill cycle wins over the fill itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_IDLE;
            i_vld_p1  <= 1'b0;
            i_resp_p1 <= '0;
            mt_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            i_vld_p1  <= resp_load;
            i_resp_p1 <= resp_nx;
            if (tlbrw_we || tlb_asid != asid_q)
                mt_valid <= 1'b0;
            else if (fill_en)
                mt_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        asid_q <= tlb_asid;
        if (state == FETCH_IDLE && i_req)
            fill_va_p1 <= i_vaddr;
        if (fill_en)
            mt <= '{vpn2: fill_va_p1[31:13], odd: fill_va_p1[12], asid: tlb_asid,
                    pfn: i_pfn, c: i_c, v: i_v};
    end
`else
    assign i_look_va = i_vaddr;
    assign i_ready   = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_vld_p1  <= 1'b0;
            i_resp_p1 <= '0;
        end else begin
            i_vld_p1  <= i_req;
            i_resp_p1 <= i_req ? tlb_translate(i_vaddr, 1'b0, kseg0_uncached,
                                               i_hit, i_pfn, i_c, i_d, i_v) : '0;
        end
    end
`endif

    assign i_resp_valid = i_vld_p1;
    assign i_paddr      = i_resp_p1.paddr;
    assign i_cached     = i_resp_p1.cached;
    assign i_ex         = i_resp_p1.ex;
    assign i_exccode    = i_resp_p1.exccode;
    assign i_refill     = i_resp_p1.refill;

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: directed vectors push expected responses, a negedge monitor pops.
`timescale 1ns/1ps
module tb_tlb_unit;
    import tlb_unit_pkg::*;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             tlbrw_we;
    logic [IDX_W-1:0] tlbrw_index;
    tlb_entry_t       tlbrw_wdata;
    tlb_entry_t       tlbrw_rdata;
    logic [31:0]      tlbp_entry_hi;
    logic [31:0]      tlbp_index;
    logic [7:0]       tlb_asid;
    logic             kseg0_uncached;
    logic             i_req, i_ready;
    logic [31:0]      i_vaddr;
    logic             i_resp_valid, i_cached, i_ex, i_refill;
    logic [31:0]      i_paddr;
    logic [4:0]       i_exccode;
    logic             d_req, d_is_store;
    logic [31:0]      d_vaddr;
    logic             d_resp_valid, d_cached, d_ex, d_refill;
    logic [31:0]      d_paddr;
    logic [4:0]       d_exccode;

    tlb_unit dut (
        .clk(clk), .reset(reset),
        .tlbrw_we(tlbrw_we), .tlbrw_index(tlbrw_index), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
        .tlb_asid(tlb_asid), .kseg0_uncached(kseg0_uncached),
        .i_req(i_req), .i_ready(i_ready), .i_vaddr(i_vaddr),
        .i_resp_valid(i_resp_valid), .i_paddr(i_paddr), .i_cached(i_cached),
        .i_ex(i_ex), .i_exccode(i_exccode), .i_refill(i_refill),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_is_store(d_is_store),
        .d_resp_valid(d_resp_valid), .d_paddr(d_paddr), .d_cached(d_cached),
        .d_ex(d_ex), .d_exccode(d_exccode), .d_refill(d_refill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        tlb_resp_t r;
        int        stamp;
        int        lat;
        bit        chk_addr;
        string     name;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   errors = 0;
    int   checks = 0;

`ifdef ITLB_MICRO_EN
    int ml = 2;
`else
    int ml = 1;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic cmp_resp(input exp_t e, input tlb_resp_t act);
        check({e.name, "_exc"}, 128'({act.ex, act.exccode, act.refill}),
              128'({e.r.ex, e.r.exccode, e.r.refill}));
        if (e.chk_addr) begin
            check({e.name, "_paddr"}, 128'(act.paddr), 128'(e.r.paddr));
            check({e.name, "_cached"}, 128'(act.cached), 128'(e.r.cached));
        end
        check({e.name, "_latency"}, 128'(cyc - e.stamp), 128'(e.lat));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (d_resp_valid) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected: response paddr %0h with nothing expected", d_paddr);
            end else begin
                e = dq.pop_front();
                cmp_resp(e, '{d_paddr, d_cached, d_ex, d_exccode, d_refill});
            end
        end
        if (i_resp_valid) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_unexpected: response paddr %0h with nothing expected", i_paddr);
            end else begin
                e = iq.pop_front();
                cmp_resp(e, '{i_paddr, i_cached, i_ex, i_exccode, i_refill});
            end
        end
    end

    function automatic tlb_resp_t mk(input logic [31:0] pa, input logic ca, input logic ex,
                                     input logic [4:0] code, input logic rf);
        return '{pa, ca, ex, code, rf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tlbwi(input logic [IDX_W-1:0] idx, input tlb_entry_t e);
        tlbrw_we = 1'b1; tlbrw_index = idx; tlbrw_wdata = e;
        tick();
        tlbrw_we = 1'b0;
    endtask

    task automatic dreq(input logic [31:0] va, input logic st, input tlb_resp_t r,
                        input bit ca, input string nm);
        d_req = 1'b1; d_vaddr = va; d_is_store = st;
        dq.push_back('{r, cyc, 1, ca, nm});
        tick();
        d_req = 1'b0;
    endtask

    task automatic ireq(input logic [31:0] va, input tlb_resp_t r, input bit ca,
                        input int lat, input string nm);
        i_req = 1'b1; i_vaddr = va;
        iq.push_back('{r, cyc, lat, ca, nm});
        tick();
        i_req = 1'b0;
        if (lat == 2) begin
            check({nm, "_ready_low"}, 128'(i_ready), 128'(0));
            tick();
        end else begin
            check({nm, "_ready_high"}, 128'(i_ready), 128'(1));
        end
    endtask

    tlb_entry_t ent_a, ent_a2, ent_a3, ent_g, ent_x;

    initial begin
        ent_a  = '{c0: 3'd3, c1: 3'd2, asid: 8'h05, vpn2: 19'h10, pfn0: 20'h12345,
                   pfn1: 20'h0ABCD, d0: 1'b1, v0: 1'b1, d1: 1'b0, v1: 1'b0, g: 1'b0};
        ent_a2 = ent_a;  ent_a2.d0 = 1'b0;
        ent_a3 = ent_a;  ent_a3.pfn0 = 20'h55555;
        ent_g  = '{c0: 3'd2, c1: 3'd0, asid: 8'h09, vpn2: 19'h10, pfn0: 20'h77777,
                   pfn1: 20'h0, d0: 1'b1, v0: 1'b1, d1: 1'b0, v1: 1'b0, g: 1'b1};
        ent_x  = '{c0: 3'd0, c1: 3'd0, asid: 8'h00, vpn2: 19'h7FFFF, pfn0: 20'h0,
                   pfn1: 20'h0, d0: 1'b0, v0: 1'b0, d1: 1'b0, v1: 1'b0, g: 1'b0};

        reset = 1'b1; tlbrw_we = 1'b0; tlbrw_index = '0; tlbrw_wdata = '0;
        tlbp_entry_hi = '0; tlb_asid = 8'h05; kseg0_uncached = 1'b0;
        i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_is_store = 1'b0;
        repeat (2) tick();

        check("rst_i_ready", 128'(i_ready), 128'(1));
        check("rst_valids", 128'({i_resp_valid, d_resp_valid}), 128'(0));
        check("rst_paddr", 128'({i_paddr, d_paddr}), 128'(0));
        check("rst_ex_refill", 128'({i_ex, i_refill, d_ex, d_refill}), 128'(0));
        check("rst_entry0_vg", 128'({tlbrw_rdata.v0, tlbrw_rdata.v1, tlbrw_rdata.g}), 128'(0));
        reset = 1'b0;
        tick();

        tlbwi(4'd3, ent_a);
        tlbrw_index = 4'd3; #1;
        check("tlbr_idx3", 128'(tlbrw_rdata), 128'(ent_a));

        dreq(32'h0002_0ABC, 1'b0, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, "d_load_hit");
        tlb_asid = 8'h06;
        dreq(32'h0002_0ABC, 1'b0, mk(32'h0, 1'b0, 1'b1, EXCCODE_TLBL, 1'b1), 0, "d_asid_miss");

        tlbp_entry_hi = 32'h0002_0005; #1;
        check("probe_hit", 128'(tlbp_index), 128'(32'd3));
        tlbp_entry_hi = 32'h0002_0006; #1;
        check("probe_miss", 128'(tlbp_index), 128'(32'h8000_0000));

        tlb_asid = 8'h05;
        dreq(32'h0002_0ABC, 1'b1, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, "d_store_ok");
        tlbwi(4'd3, ent_a2);
        dreq(32'h0002_0ABC, 1'b1, mk(32'h0, 1'b0, 1'b1, EXCCODE_MOD, 1'b0), 0, "d_store_mod");
        dreq(32'h0002_1000, 1'b1, mk(32'h0, 1'b0, 1'b1, EXCCODE_TLBS, 1'b0), 0, "d_store_inv");
        dreq(32'h0002_1000, 1'b0, mk(32'h0, 1'b0, 1'b1, EXCCODE_TLBL, 1'b0), 0, "d_load_inv");

        tlbwi(4'd7, ent_g);
        tlb_asid = 8'h06;
        dreq(32'h0002_0ABC, 1'b0, mk(32'h7777_7ABC, 1'b0, 1'b0, 5'd0, 1'b0), 1, "d_global");
        #1;
        check("probe_global", 128'(tlbp_index), 128'(32'd7));
        tlb_asid = 8'h05;
        dreq(32'h0002_0ABC, 1'b0, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, "d_lowest_idx");

        ireq(32'hBFC0_0000, mk(32'h1FC0_0000, 1'b0, 1'b0, 5'd0, 1'b0), 1, 1, "i_kseg1");
        ireq(32'h8000_1000, mk(32'h0000_1000, 1'b1, 1'b0, 5'd0, 1'b0), 1, 1, "i_kseg0_c");
        kseg0_uncached = 1'b1;
        ireq(32'h8000_1000, mk(32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b0), 1, 1, "i_kseg0_uc");
        kseg0_uncached = 1'b0;

        d_is_store = 1'b1;
        ireq(32'h0002_0ABC, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, ml, "i_mapped_first");
        ireq(32'h0004_0000, mk(32'h0, 1'b0, 1'b1, EXCCODE_TLBL, 1'b1), 0, ml, "i_refill");
        ireq(32'h0002_0FF0, mk(32'h1234_5FF0, 1'b1, 1'b0, 5'd0, 1'b0), 1, 1, "i_micro_hit");
        tlb_asid = 8'h06; tick();
        tlb_asid = 8'h05; tick();
        ireq(32'h0002_0ABC, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, ml, "i_after_asid");
        ireq(32'h0002_0ABC, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, 1, "i_rehit");
        tlbwi(4'd9, ent_x);
        ireq(32'h0002_0ABC, mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), 1, ml, "i_after_wi");
        d_is_store = 1'b0;

        // same-cycle write and lookup: old mapping, then new mapping one cycle later
        tlbrw_we = 1'b1; tlbrw_index = 4'd3; tlbrw_wdata = ent_a3;
        d_req = 1'b1; d_vaddr = 32'h0002_0ABC; d_is_store = 1'b0;
        #1;
        check("tlbr_before_write", 128'(tlbrw_rdata), 128'(ent_a2));
        dq.push_back('{mk(32'h1234_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), cyc, 1, 1'b1, "d_old_map"});
        tick();
        tlbrw_we = 1'b0;
        dq.push_back('{mk(32'h5555_5ABC, 1'b1, 1'b0, 5'd0, 1'b0), cyc, 1, 1'b1, "d_new_map"});
        tick();
        d_req = 1'b0;

        // reset while requests are presented: nothing may come back
        reset = 1'b1; d_req = 1'b1; d_vaddr = 32'h0002_0ABC;
        i_req = 1'b1; i_vaddr = 32'h0002_0ABC;
        tick();
        reset = 1'b0; d_req = 1'b0; i_req = 1'b0;
        check("rst_inflight_valids", 128'({i_resp_valid, d_resp_valid}), 128'(0));
        check("rst_inflight_ready", 128'(i_ready), 128'(1));
        tlbrw_index = 4'd3; #1;
        check("rst_entry3_v0", 128'(tlbrw_rdata.v0), 128'(0));
        dreq(32'h0002_0ABC, 1'b0, mk(32'h0, 1'b0, 1'b1, EXCCODE_TLBL, 1'b0), 0, "d_after_reset");

        repeat (3) tick();
        check("scoreboard_drained", 128'(iq.size() + dq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
